// File: rtl/restador_serie.sv
// restador_serie: bit-serial two's-complement subtractor.
// Computes diff = a - b one bit per clock, LSB first, with a single borrow
// flip-flop. The 8-bit operands are sign-extended to 9 bits, so every
// difference fits in the 9-bit signed result without overflow.
// A request is accepted only in IDLE. An operation takes 9 SHIFT cycles and
// 1 DONE cycle, so the module can start a new operation every 11 cycles.
module restador_serie (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic signed [7:0] a,
    input  logic signed [7:0] b,
    output logic signed [8:0] diff,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'd8;

    state_t      state_q;
    logic [8:0]  a_q;        // minuend shift register, current bit at [0]
    logic [8:0]  b_q;        // subtrahend shift register, current bit at [0]
    logic [8:0]  res_q;      // partial result, new bits enter at [8]
    logic        borrow_q;
    logic [3:0]  cnt_q;      // index of the bit being processed
    logic [8:0]  diff_q;
    logic        busy_q;
    logic        done_q;

    logic        bit_d;
    logic        borrow_d;
    logic [3:0]  cnt_d;
    logic [8:0]  res_d;
    logic        last_d;

    // Full-subtractor slice for the current bit and next shift values
    always_comb begin
        bit_d    = a_q[0] ^ b_q[0] ^ borrow_q;
        borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        cnt_d    = cnt_q + 4'd1;
        res_d    = {bit_d, res_q[8:1]};
        last_d   = (cnt_q == LAST_BIT);
    end

    // Control FSM and datapath registers with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= {a[7], a};
                        b_q      <= {b[7], b};
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q      <= {a_q[8], a_q[8:1]};
                    b_q      <= {b_q[8], b_q[8:1]};
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_d;
                    if (last_d) begin
                        // Bit 8 goes straight into diff so it is valid together with done
                        diff_q  <= res_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign diff = diff_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_restador_serie.sv
// Bench for restador_serie: directed operations with literal results, plus
// a timeline model that predicts busy/done/diff for every cycle.
module tb_restador_serie;

    logic              clk;
    logic              rst;
    logic              start;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic        [8:0] diff;
    logic              busy;
    logic              done;

    int tests;
    int fails;
    bit checking;

    restador_serie dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: ph counts cycles since an accepted start
    // (1..9 busy, 10 done, 0 idle); result is plain integer a - b.
    int         ph;
    int         la;
    int         lb;
    logic [8:0] m_diff;

    always @(posedge clk) begin
        if (rst) begin
            ph     <= 0;
            m_diff <= '0;
        end else if (ph == 0) begin
            if (start) begin
                ph <= 1;
                la <= int'(a);
                lb <= int'(b);
            end
        end else if (ph == 9) begin
            ph     <= 10;
            m_diff <= 9'(la - lb);
        end else if (ph == 10) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    // Compare every cycle against the model, away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            chk("model_busy", int'(busy), (ph >= 1 && ph <= 9) ? 1 : 0);
            chk("model_done", int'(done), (ph == 10) ? 1 : 0);
            chk("model_diff", int'(diff), int'(m_diff));
        end
    end

    // One operation; a/b scrambled after the start edge; optional start
    // pulse at SHIFT cycle dc; then checks that no extra done follows.
    task automatic op(input logic signed [7:0] ta, input logic signed [7:0] tb_v,
                      input logic [8:0] exp, input int dc, input string name);
        int cyc;
        int nb;
        int extra;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nb = 0;
        while (!done && cyc < 20) begin
            a = 8'($urandom); b = 8'($urandom);
            start = (cyc == dc);
            if (busy) nb++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({name, "_done_seen"}, int'(done), 1);
        chk({name, "_latency"}, cyc, 10);
        chk({name, "_diff"}, int'(diff), int'(exp));
        chk({name, "_busy_cycles"}, nb, 9);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk({name, "_extra_done"}, extra, 0);
    endtask

    initial begin
        int cyc;
        int np;
        int last_c;
        int gap_bad;
        int nd;
        tests = 0; fails = 0; checking = 1'b0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        @(posedge clk);
        #1 checking = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_diff", int'(diff), 0);
        rst = 1'b0;

        op(8'sd10,   8'sd20,   9'h1F6, 0, "a10_b20");
        op(-8'sd50,  8'sd75,   9'h183, 0, "m50_75");
        op(-8'sd50,  -8'sd50,  9'h000, 0, "m50_m50");
        op(8'sd127,  -8'sd127, 9'h0FE, 0, "127_m127");
        op(-8'sd128, 8'sd127,  9'h101, 0, "m128_127");
        op(8'sd127,  -8'sd128, 9'h0FF, 0, "127_m128");
        op(8'sd33,   -8'sd7,   9'h028, 3, "disturb");

        // Reset at SHIFT cycle 4 aborts the operation
        @(negedge clk);
        a = 8'sd5; b = 8'sd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_diff", int'(diff), 0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        op(8'sd5, 8'sd3, 9'h002, 0, "after_abort");

        // Reset while in DONE clears done the next cycle
        @(negedge clk);
        a = -8'sd1; b = 8'sd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rstdone_seen", int'(done), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstdone_cleared", int'(done), 0);
        chk("rstdone_diff", int'(diff), 0);

        // start held high for 25 cycles: done pulses 11 cycles apart
        @(negedge clk);
        np = 0; last_c = 0; gap_bad = 0;
        for (int c = 0; c < 45; c++) begin
            start = (c < 25);
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            if (done) begin
                if (np > 0 && (c - last_c) != 11) gap_bad++;
                np++;
                last_c = c;
            end
        end
        start = 1'b0;
        chk("b2b_pulses", np, 3);
        chk("b2b_gap_errors", gap_bad, 0);

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
